// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, lane constants and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LANE_W = 2;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables/replication, load extraction/extension,
// and alignment legality for a given funct3 and byte lane.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [31:0]       store_data_i,
  input  logic [31:0]       rdata_i,
  output logic [3:0]        be_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       load_val_o,
  output logic              misalign_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata_i >> {lane_i, 3'b000};
    be_o       = '0;
    wdata_o    = store_data_i;
    load_val_o = '0;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o       = BE_BYTE << lane_i;
        wdata_o    = {4{store_data_i[7:0]}};
        load_val_o = (funct3_i == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'h0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        misalign_o = lane_i[0];
        be_o       = BE_HALF << lane_i;
        wdata_o    = {2{store_data_i[15:0]}};
        load_val_o = (funct3_i == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                        : {16'h0, shifted[15:0]};
      end
      F3_W: begin
        misalign_o = (lane_i != '0);
        be_o       = BE_WORD;
        load_val_o = rdata_i;
      end
      // Reserved encodings are rejected the same way as misaligned accesses.
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns an ALU effective address plus funct3 into a single bus transaction
// with timeout, stalling the core until the access completes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [2:0]        f3_q, f3_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              misalign_q, misalign_d;
  logic              fault_q, fault_d;

  logic              access;
  logic [2:0]        al_f3;
  logic [LANE_W-1:0] al_lane;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_load;
  logic              al_misalign;

  assign access = mem_read | mem_write;

  // One aligner serves both phases: live inputs in IDLE, latched funct3/lane while BUSY.
  assign al_f3   = (state_q == StIdle) ? funct3 : f3_q;
  assign al_lane = (state_q == StIdle) ? address[LANE_W-1:0] : lane_q;

  lsu_align u_align (
    .funct3_i     (al_f3),
    .lane_i       (al_lane),
    .store_data_i (store_data),
    .rdata_i      (bus_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_val_o   (al_load),
    .misalign_o   (al_misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    misalign_d  = 1'b0;
    fault_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access && al_misalign) begin
          misalign_d  = 1'b1;
          load_data_d = '0;
        end else if (access) begin
          state_d     = StBusy;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {address[31:2], 2'b00};
          bus_be_d    = mem_write ? al_be : 4'b0000;
          bus_wdata_d = mem_write ? al_wdata : 32'h0;
          f3_d        = funct3;
          lane_d      = address[LANE_W-1:0];
        end
      end
      StBusy: begin
        if (bus_ready) begin
          state_d   = StDone;
          bus_req_d = 1'b0;
          cnt_d     = '0;
          if (bus_err) begin
            fault_d     = 1'b1;
            load_data_d = '0;
          end else if (!bus_we_q) begin
            load_data_d = al_load;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = StDone;
          bus_req_d   = 1'b0;
          cnt_d       = '0;
          fault_d     = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      load_data_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      misalign_q  <= misalign_d;
      fault_q     <= fault_d;
    end
  end

  assign stall     = ((state_q == StIdle) && access && !al_misalign) || (state_q == StBusy);
  assign load_data = load_data_q;
  assign misalign  = misalign_q;
  assign fault     = fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random accesses against a
// behavioural model of lane selection, extension, alignment and bus timing.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] address, store_data;
  logic [31:0] load_data;
  logic        stall, misalign, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ld = 32'h0;

  load_store_unit #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .misalign   (misalign),
    .fault      (fault),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lane,
                                           input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * lane);
    case (f3)
      3'd0:    return s[7]  ? (32'hFFFFFF00 | (s & 32'hFF))   : (s & 32'hFF);
      3'd1:    return s[15] ? (32'hFFFF0000 | (s & 32'hFFFF)) : (s & 32'hFFFF);
      3'd4:    return s & 32'hFF;
      3'd5:    return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rdata, input logic err, input int delay);
    logic        ok;
    logic        timeout;
    int          lane;
    int          n;
    logic [31:0] be_e;
    logic [31:0] wd_e;
    lane = int'(addr[1:0]);
    case (f3)
      3'd0, 3'd4: ok = 1'b1;
      3'd1, 3'd5: ok = (addr[0] == 1'b0);
      3'd2:       ok = (addr[1:0] == 2'b00);
      default:    ok = 1'b0;
    endcase
    mem_read = rd; mem_write = wr; funct3 = f3; address = addr; store_data = sd;
    #1;
    check("stall_req", stall, ok);
    tick();
    if (!ok) begin
      check("misalign", misalign, 1);
      check("ld_misal", load_data, 0);
      check("req_misal", bus_req, 0);
      check("stall_misal", stall, 0);
      exp_ld = 32'h0;
      mem_read = 0; mem_write = 0;
      tick();
      check("misal_pulse", misalign, 0);
      return;
    end
    case (f3)
      3'd0, 3'd4: begin be_e = 32'h1 << lane; wd_e = (sd & 32'hFF) * 32'h01010101; end
      3'd1, 3'd5: begin be_e = 32'h3 << lane; wd_e = (sd & 32'hFFFF) * 32'h00010001; end
      default:    begin be_e = 32'hF;         wd_e = sd; end
    endcase
    check("req_start", bus_req, 1);
    check("bus_addr", bus_addr, addr & 32'hFFFFFFFC);
    check("bus_we", bus_we, wr);
    check("bus_be", bus_be, wr ? be_e : 32'h0);
    if (wr) check("bus_wdata", bus_wdata, wd_e);
    n = 0;
    while (bus_req === 1'b1 && n < 40) begin
      check("stall_busy", stall, 1);
      bus_ready = (n == delay); bus_rdata = rdata; bus_err = err;
      tick();
      n++;
    end
    bus_ready = 0; bus_err = 0;
    timeout = (delay >= TIMEOUT);
    check("req_cycles", n, timeout ? TIMEOUT : delay + 1);
    check("stall_done", stall, 0);
    check("fault", fault, timeout || err);
    if (timeout || err) exp_ld = 32'h0;
    else if (!wr) exp_ld = ref_load(f3, lane, rdata);
    check("load_data", load_data, exp_ld);
    mem_read = 0; mem_write = 0;
    tick();
    check("fault_clr", fault, 0);
    check("no_retrig", bus_req, 0);
    check("stall_idle", stall, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; mem_read = 0; mem_write = 0; funct3 = 0; address = 0; store_data = 0;
    bus_ready = 0; bus_rdata = 0; bus_err = 0;
    tick(); tick();
    check("rst_req", bus_req, 0);
    check("rst_ld", load_data, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_flags", {bus_we, misalign, fault, stall}, 0);
    reset = 0;
    tick();

    run_access(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    run_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
    check("lb_val", load_data, 32'hFFFFFF80);
    run_access(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 0, 1);
    check("lbu_val", load_data, 32'h00000080);
    run_access(0, 1, 3'd1, 32'h22, 32'h0000ABCD, 32'h0, 0, 2);
    run_access(1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0);
    run_access(1, 0, 3'd2, 32'h40, 32'h0, 32'h12345678, 0, 3);
    run_access(1, 0, 3'd2, 32'h44, 32'h0, 32'h0, 0, 30);
    run_access(1, 0, 3'd2, 32'h40, 32'h0, 32'h12345678, 0, 0);
    run_access(1, 0, 3'd1, 32'h48, 32'h0, 32'h5555AAAA, 1, 1);
    run_access(1, 1, 3'd2, 32'h80, 32'hCAFEF00D, 32'h0, 0, 15);

    // Reset while a read is outstanding.
    mem_read = 1; funct3 = 3'd2; address = 32'h200;
    tick();
    check("mid_req", bus_req, 1);
    reset = 1; mem_read = 0;
    tick();
    reset = 0;
    check("rst_mid_req", bus_req, 0);
    check("rst_mid_stall", stall, 0);
    check("rst_mid_ld", load_data, 0);
    exp_ld = 32'h0;
    tick();
    check("rst_mid_idle", bus_req, 0);
    run_access(1, 0, 3'd2, 32'h204, 32'h0, 32'h0BADCAFE, 0, 1);

    for (int i = 0; i < 60; i++) begin
      int          kind;
      int          d;
      logic        e;
      logic [2:0]  f3;
      kind = $urandom_range(0, 2);
      d    = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
      e    = ($urandom_range(0, 7) == 0);
      f3   = 3'($urandom_range(0, 7));
      run_access(kind != 1, kind != 0, f3, $urandom, $urandom, $urandom, e, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
